// File: rtl/cnn_pkg.sv
// Shared constants and sizing helpers for the CNN datapath stages.
package cnn_pkg;
    localparam int POOL_MAX = 0;
    localparam int POOL_AVG = 1;

    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width that holds a full P*P window sum without overflow.
    function automatic int pool_acc_bw(input int bw, input int p);
        return bw + 2 * $clog2(p);
    endfunction
endpackage

// File: rtl/pool_col_buffer.sv
// Column buffer for pooling partials: asynchronous read, synchronous write,
// so a read and a write of the same index in one cycle sees the old value.
module pool_col_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 12,
    parameter int W     = 66
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [clog2_safe(DEPTH)-1:0] waddr,
    input  logic [W-1:0]                 wdata,
    input  logic [clog2_safe(DEPTH)-1:0] raddr,
    output logic [W-1:0]                 rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pool_stream_core.sv
// Streaming P x P max/average pooling stage with optional ReLU, output
// coordinate tags, end-of-frame pulse and synchronous frame abort.
module pool_stream_core
    import cnn_pkg::*;
#(
    parameter int CH   = 3,
    parameter int BW   = 20,
    parameter int IW   = 24,
    parameter int IH   = 24,
    parameter int P    = 2,
    parameter int MODE = POOL_MAX,
    parameter int RELU = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_clear,
    input  logic                          i_valid,
    input  logic [CH*BW-1:0]              i_fmap,
    output logic                          o_valid,
    output logic [CH*BW-1:0]              o_fmap,
    output logic [clog2_safe(IW/P)-1:0]   o_x,
    output logic [clog2_safe(IH/P)-1:0]   o_y,
    output logic                          o_frame_done
);
    localparam int OW  = IW / P;
    localparam int OH  = IH / P;
    localparam int LP  = $clog2(P);
    localparam int SH  = 2 * LP;
    localparam int ABW = pool_acc_bw(BW, P);
    localparam int XW  = clog2_safe(IW);
    localparam int YW  = clog2_safe(IH);
    localparam int CW  = clog2_safe(OW);
    localparam int RW  = clog2_safe(OH);

    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [LP-1:0]     sx, sy;
    logic [CW-1:0]     col, buf_idx;
    logic [RW-1:0]     row;
    logic              in_x, in_y, h_end, v_end;
    logic              buf_we, fire, last;
    logic [CH*ABW-1:0] pix_ext, hp, h_res, buf_rd, buf_wd, combo;
    logic [CH*BW-1:0]  o_next;

    function automatic logic [ABW-1:0] op(input logic [ABW-1:0] a, input logic [ABW-1:0] b);
        logic [ABW-1:0] r;
        if (MODE == POOL_AVG) r = a + b;
        else                  r = ($signed(a) > $signed(b)) ? a : b;
        return r;
    endfunction

    // Average: floor division by P*P via arithmetic shift; both modes fit BW after this.
    function automatic logic [BW-1:0] finalize(input logic [ABW-1:0] a);
        logic [ABW-1:0] s;
        logic [BW-1:0]  r;
        if (MODE == POOL_AVG) s = $signed(a) >>> SH;
        else                  s = a;
        r = s[BW-1:0];
        if (RELU != 0 && r[BW-1]) r = '0;
        return r;
    endfunction

    assign sx    = x[LP-1:0];
    assign sy    = y[LP-1:0];
    assign col   = CW'(x >> LP);
    assign row   = RW'(y >> LP);
    assign in_x  = {1'b0, x} < (XW+1)'(OW * P);
    assign in_y  = {1'b0, y} < (YW+1)'(OH * P);
    assign h_end = (sx == LP'(P - 1));
    assign v_end = (sy == LP'(P - 1));

    // Ragged right-hand columns never touch the buffer, so the index stays in range.
    assign buf_idx = in_x ? col : '0;
    assign buf_we  = i_valid && !i_clear && h_end && in_x && in_y;
    assign fire    = buf_we && v_end;
    assign last    = fire && (col == CW'(OW - 1)) && (row == RW'(OH - 1));

    always_comb begin
        pix_ext = '0;
        h_res   = '0;
        combo   = '0;
        buf_wd  = '0;
        o_next  = '0;
        for (int c = 0; c < CH; c++) begin
            pix_ext[c*ABW +: ABW] = {{SH{i_fmap[c*BW+BW-1]}}, i_fmap[c*BW +: BW]};
            h_res[c*ABW +: ABW]   = op(hp[c*ABW +: ABW], pix_ext[c*ABW +: ABW]);
            combo[c*ABW +: ABW]   = op(buf_rd[c*ABW +: ABW], h_res[c*ABW +: ABW]);
            buf_wd[c*ABW +: ABW]  = (sy == '0) ? h_res[c*ABW +: ABW] : combo[c*ABW +: ABW];
            o_next[c*BW +: BW]    = finalize(combo[c*ABW +: ABW]);
        end
    end

    pool_col_buffer #(
        .DEPTH (OW),
        .W     (CH * ABW)
    ) u_col_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_idx),
        .wdata (buf_wd),
        .raddr (buf_idx),
        .rdata (buf_rd)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x  <= '0;
            y  <= '0;
            hp <= '0;
        end else if (i_clear) begin
            x  <= '0;
            y  <= '0;
            hp <= '0;
        end else if (i_valid) begin
            hp <= (sx == '0) ? pix_ext : h_res;
            if (x == XW'(IW - 1)) begin
                x <= '0;
                y <= (y == YW'(IH - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_fmap       <= '0;
            o_x          <= '0;
            o_y          <= '0;
        end else begin
            o_valid      <= fire;
            o_frame_done <= last;
            if (fire) begin
                o_fmap <= o_next;
                o_x    <= col;
                o_y    <= row;
            end
        end
    end
endmodule

// File: tb/tb_pool_stream_core.sv
// Randomised bench for pool_stream_core: three configurations checked against
// a window-level reference model, plus literal pins on the model itself.
module tb_pool_stream_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v0, c0, v1, c1, v2, c2;
    logic [59:0] f0, f1, f2;
    logic        ov0, ov1, ov2, od0, od1, od2;
    logic [59:0] of0, of1, of2;
    logic [3:0]  ox0, oy0;
    logic [1:0]  ox1, oy1, ox2, oy2;

    typedef struct {
        int e0;
        int e1;
        int e2;
        int ox;
        int oy;
        bit done;
        int cyc;
    } exp_t;

    exp_t eq[3][$];
    int   frm[24][24][3];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   ocnt[3];
    int   dcnt[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool_stream_core u_max (
        .clk(clk), .reset_n(reset_n), .i_clear(c0), .i_valid(v0), .i_fmap(f0),
        .o_valid(ov0), .o_fmap(of0), .o_x(ox0), .o_y(oy0), .o_frame_done(od0));

    pool_stream_core #(.IW(8), .IH(8), .MODE(1)) u_avg (
        .clk(clk), .reset_n(reset_n), .i_clear(c1), .i_valid(v1), .i_fmap(f1),
        .o_valid(ov1), .o_fmap(of1), .o_x(ox1), .o_y(oy1), .o_frame_done(od1));

    pool_stream_core #(.IW(7), .IH(7), .MODE(1), .RELU(1)) u_small (
        .clk(clk), .reset_n(reset_n), .i_clear(c2), .i_valid(v2), .i_fmap(f2),
        .o_valid(ov2), .o_fmap(of2), .o_x(ox2), .o_y(oy2), .o_frame_done(od2));

    // Window value from its top-left input pixel, straight from the pooling rules.
    function automatic int win(int x0, int y0, int p, int mode, int relu, int ch);
        int acc;
        int n;
        acc = (mode == 1) ? 0 : frm[y0][x0][ch];
        for (int j = 0; j < p; j++)
            for (int i = 0; i < p; i++) begin
                if (mode == 1) acc += frm[y0+j][x0+i][ch];
                else if (frm[y0+j][x0+i][ch] > acc) acc = frm[y0+j][x0+i][ch];
            end
        if (mode == 1) begin
            n = p * p;
            if (acc < 0 && (acc % n) != 0) acc = acc / n - 1;
            else acc = acc / n;
        end
        if (relu != 0 && acc < 0) acc = 0;
        return acc;
    endfunction

    function automatic logic [59:0] pix(int x, int y);
        logic [59:0] r;
        int t;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            t = frm[y][x][c];
            r[c*20 +: 20] = t[19:0];
        end
        return r;
    endfunction

    task automatic expect_eq(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic put(int d, bit v, bit c, logic [59:0] f);
        case (d)
            0: begin v0 = v; c0 = c; f0 = f; end
            1: begin v1 = v; c1 = c; f1 = f; end
            default: begin v2 = v; c2 = c; f2 = f; end
        endcase
        @(posedge clk);
        #1;
        v0 = 1'b0; c0 = 1'b0;
        v1 = 1'b0; c1 = 1'b0;
        v2 = 1'b0; c2 = 1'b0;
    endtask

    task automatic run_frame(int d, int w, int h, int p, int mode, int relu, int gap,
                             int stop_x, int stop_y, bit abort);
        int   ow;
        int   oh;
        exp_t e;
        ow = w / p;
        oh = h / p;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                repeat ($urandom_range(0, gap)) put(d, 1'b0, 1'b0, '0);
                if (abort && x == stop_x && y == stop_y) begin
                    put(d, 1'b1, 1'b1, pix(x, y));
                    return;
                end
                if (x % p == p - 1 && y % p == p - 1 && x < ow * p && y < oh * p) begin
                    e.ox   = x / p;
                    e.oy   = y / p;
                    e.e0   = win(x - p + 1, y - p + 1, p, mode, relu, 0);
                    e.e1   = win(x - p + 1, y - p + 1, p, mode, relu, 1);
                    e.e2   = win(x - p + 1, y - p + 1, p, mode, relu, 2);
                    e.done = (e.ox == ow - 1) && (e.oy == oh - 1);
                    e.cyc  = cyc + 1;
                    eq[d].push_back(e);
                end
                put(d, 1'b1, 1'b0, pix(x, y));
                if (x == stop_x && y == stop_y) return;
            end
    endtask

    task automatic check(int d, bit v, bit dn, logic [59:0] f, int ox, int oy);
        exp_t e;
        int   g0, g1, g2;
        if (v) begin
            ocnt[d]++;
            if (dn) dcnt[d]++;
            tests++;
            if (eq[d].size() == 0) begin
                fails++;
                $display("FAIL out%0d_unexpected: got output at (%0d,%0d), expected none", d, ox, oy);
            end else begin
                e  = eq[d].pop_front();
                g0 = int'($signed(f[19:0]));
                g1 = int'($signed(f[39:20]));
                g2 = int'($signed(f[59:40]));
                if (g0 != e.e0 || g1 != e.e1 || g2 != e.e2 || ox != e.ox || oy != e.oy
                    || dn != e.done || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL out%0d: got (%0d,%0d) [%0d %0d %0d] done=%0d cyc=%0d, expected (%0d,%0d) [%0d %0d %0d] done=%0d cyc=%0d",
                             d, ox, oy, g0, g1, g2, dn, cyc,
                             e.ox, e.oy, e.e0, e.e1, e.e2, e.done, e.cyc);
                end
            end
        end else if (dn) begin
            tests++;
            fails++;
            $display("FAIL done%0d_alone: got frame_done=1 with valid=0, expected 0", d);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check(0, ov0, od0, of0, int'(ox0), int'(oy0));
            check(1, ov1, od1, of1, int'(ox1), int'(oy1));
            check(2, ov2, od2, of2, int'(ox2), int'(oy2));
        end
    end

    task automatic start_phase();
        for (int d = 0; d < 3; d++) begin
            ocnt[d] = 0;
            dcnt[d] = 0;
        end
    endtask

    task automatic finish_phase(string name, int d, int n_out, int n_done);
        repeat (4) @(posedge clk);
        #1;
        expect_eq({name, "_drain"}, eq[d].size(), 0);
        expect_eq({name, "_outputs"}, ocnt[d], n_out);
        expect_eq({name, "_done"}, dcnt[d], n_done);
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 24; x++)
                for (int c = 0; c < 3; c++)
                    frm[y][x][c] = y * 24 + x + c * 1000;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < 24; y++)
            for (int x = 0; x < 24; x++)
                for (int c = 0; c < 3; c++)
                    frm[y][x][c] = int'($urandom_range(0, 1048575)) - 524288;
    endtask

    task automatic set_neg_window();
        for (int c = 0; c < 3; c++) begin
            frm[0][0][c] = -3;
            frm[0][1][c] = -2;
            frm[1][0][c] = -2;
            frm[1][1][c] = -2;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        v0 = 0; c0 = 0; f0 = '0;
        v1 = 0; c1 = 0; f1 = '0;
        v2 = 0; c2 = 0; f2 = '0;
        for (int d = 0; d < 3; d++) begin ocnt[d] = 0; dcnt[d] = 0; end

        #23;
        expect_eq("rst_valid", int'(ov0), 0);
        expect_eq("rst_done", int'(od0), 0);
        expect_eq("rst_fmap_bits", $countones(of0), 0);
        expect_eq("rst_xy", int'(ox0) + int'(oy0), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Max mode on the raster ramp
        fill_ramp();
        expect_eq("pin_ramp_3_5_c1", win(6, 10, 2, 0, 0, 1), 1271);
        expect_eq("pin_ramp_11_11_c2", win(22, 22, 2, 0, 0, 2), 2575);
        start_phase();
        run_frame(0, 24, 24, 2, 0, 0, 0, -1, -1, 1'b0);
        finish_phase("ramp", 0, 144, 1);

        // Max mode, random data, random gaps
        fill_rand();
        start_phase();
        run_frame(0, 24, 24, 2, 0, 0, 3, -1, -1, 1'b0);
        finish_phase("gapped", 0, 144, 1);

        // Average with a negative window
        fill_rand();
        set_neg_window();
        expect_eq("pin_avg_neg", win(0, 0, 2, 1, 0, 0), -3);
        expect_eq("pin_avg_relu", win(0, 0, 2, 1, 1, 1), 0);
        start_phase();
        run_frame(1, 8, 8, 2, 1, 0, 0, -1, -1, 1'b0);
        run_frame(1, 8, 8, 2, 1, 0, 3, -1, -1, 1'b0);
        finish_phase("avg", 1, 32, 2);

        // 7x7 frame with ReLU; ragged column and row are re-randomised between runs
        start_phase();
        run_frame(2, 7, 7, 2, 1, 1, 2, -1, -1, 1'b0);
        for (int i = 0; i < 7; i++)
            for (int c = 0; c < 3; c++) begin
                frm[i][6][c] = int'($urandom_range(0, 1048575)) - 524288;
                frm[6][i][c] = int'($urandom_range(0, 1048575)) - 524288;
            end
        run_frame(2, 7, 7, 2, 1, 1, 0, -1, -1, 1'b0);
        finish_phase("small", 2, 18, 2);

        // Abort at (5,3) with a pixel in the same cycle, then restart
        fill_ramp();
        run_frame(0, 24, 24, 2, 0, 0, 0, 5, 3, 1'b1);
        @(negedge clk);
        expect_eq("abort_no_out", int'(ov0), 0);
        @(posedge clk);
        #1;
        start_phase();
        run_frame(0, 24, 24, 2, 0, 0, 1, -1, -1, 1'b0);
        finish_phase("restart", 0, 144, 1);

        // Asynchronous reset mid-frame, right after an output
        fill_rand();
        run_frame(0, 24, 24, 2, 0, 0, 0, 3, 5, 1'b0);
        expect_eq("pre_rst_valid", int'(ov0), 1);
        #2;
        reset_n = 1'b0;
        eq[0].delete();
        #1;
        expect_eq("mid_rst_valid", int'(ov0), 0);
        expect_eq("mid_rst_fmap_bits", $countones(of0), 0);
        expect_eq("mid_rst_xy", int'(ox0) + int'(oy0), 0);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        start_phase();
        run_frame(0, 24, 24, 2, 0, 0, 0, -1, -1, 1'b0);
        run_frame(0, 24, 24, 2, 0, 0, 0, -1, -1, 1'b0);
        finish_phase("b2b", 0, 288, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pool_stream_core.md
# pool_stream_core

Parametrised streaming pooling stage for the CNN datapath: consumes a raster-order, multi-channel feature map (one pixel per `i_valid`, all channels in parallel) and emits one pooled pixel per P×P window, in raster order. It replaces the fixed 2×2 max-pool stage between first-layer convolution and second-layer convolution. It adds:
- selectable max/average mode;
- optional output ReLU;
- output coordinate tags;
- an end-of-frame pulse;
- a synchronous frame abort.

## Interface
- `CH`, 3, channel count (packed side by side, channel c at bits `[c*BW +: BW]`)
- `BW`, 20, signed width per channel, input and output
- `IW`, 24, input frame width
- `IH`, 24, input frame height
- `P`, 2, window size and stride; a power of two, from 2 to 8
- `MODE`, 0, 0 = max, 1 = average (truncating arithmetic shift)
- `RELU`, 0, 1 = clamp negative outputs to 0
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `i_clear`  in  1  synchronous frame abort
- `i_valid`  in  1  input pixel strobe; gaps allowed
- `i_fmap`  in  `CH*BW`  input pixel, signed per channel
- `o_valid`  out  1  pooled pixel strobe
- `o_fmap`  out  `CH*BW`  pooled pixel, signed per channel
- `o_x`  out  `$clog2(IW/P)`  output column
- `o_y`  out  `$clog2(IH/P)`  output row
- `o_frame_done`  out  1  one-cycle pulse, coincident with the last `o_valid` of a frame

## Operation
- **Output size:** `OW = IW/P`, `OH = IH/P` (floor).
  - Input columns `x >= OW*P` are consumed but ignored.
  - Input rows `y >= OH*P` are consumed but ignored.
- **Input counters:**
  - `x` increments on each `i_valid` and wraps at `IW-1`.
  - `y` increments on each `x` wrap and wraps at `IH-1`.
  - Derived per pixel: `sx = x%P`, `sy = y%P`, `col = x/P`.
- **Horizontal partial:** a `CH`-wide register.
  - Loaded with the pixel when `sx==0`.
  - Otherwise updated to `op(partial, pixel)`.
- **Column buffer:** `OW` entries × `CH` channels.
  - When `sx==P-1`: if `sy==0`, write `op`-combined horizontal result to `buf[col]`; else write `op(buf[col], that result)`.
- **op:**
  - MODE 0: signed max.
  - MODE 1: signed add at accumulator width `ABW = BW + 2*log2(P)` (no overflow possible).
- **Output:** generated when `sx==P-1 && sy==P-1` and the pixel lies inside the `OW×OH` region.
  - MODE 1 result = `acc >>> 2*log2(P)`, arithmetic, rounding toward −∞.
  - RELU=1: any negative channel becomes 0, per channel.
  - The final value is `BW` bits; max always fits, and average fits after the shift.
- **Coordinates and end of frame:**
  - `o_x`, `o_y` give the window's output coordinate.
  - `o_frame_done` is asserted with output `(OW-1, OH-1)`.
- **`i_clear`:**
  - Zeroes `x`, `y` and the partial registers, and invalidates the buffer. No buffer reset is needed, because `sy==0` overwrites.
  - Suppresses any output in the following cycle.
  - `i_clear` together with `i_valid`: clear wins and the pixel is dropped.

## Timing
- Latency: the `o_valid` register asserts 1 cycle after the `i_valid` of the window's final pixel.
- Max throughput: 1 pixel per cycle, sustained indefinitely, with no back-pressure.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle right after the last pixel of frame N. `o_frame_done` for frame N does not interfere.
- Reset values:
  - `o_valid=0`, `o_frame_done=0`, `o_fmap=0`, `o_x=0`, `o_y=0`.
  - Counters are 0; the partials are 0.
- Between strobes: `o_fmap`, `o_x`, `o_y` hold their last value and are don't-care to consumers.
- Reset mid-frame: takes effect asynchronously. The next `i_valid` after release is pixel (0,0).
- Gaps in `i_valid`: state is frozen, and the output is bit-identical to the gapless case.

## Structure
- **Shared package `cnn_pkg`:**
  - mode constants `POOL_MAX=0`, `POOL_AVG=1`
  - function `clog2_safe`
  - function `pool_acc_bw(BW,P)`
  - reused by the conv stages.
- **Sub-module `pool_col_buffer`:** parametrised `OW × CH*ABW` register array with one read port (index `col`) and one write port.
  - Same-cycle read-then-write of the same index is required.
  - Kept separate so that it can later map to distributed RAM.
- **Top level:** counters, horizontal partial, `op`/shift/ReLU, and the output registers.

## Test plan
- **Max, defaults (`IW=IH=24`, P=2, CH=3):** raster ramp, channel c pixel = `y*24+x+c*1000`.
  - Response: 144 outputs; output (i,j) channel c = `(2j+1)*24+2i+1+c*1000`.
  - `o_frame_done` occurs only with (11,11).
- **Average with negatives (MODE=1, P=2):** window {−3,−2,−2,−2}.
  - Response: sum −9, output −3 (floor).
  - With RELU=1, the output is 0.
- **Non-multiple size (`IW=IH=7`, P=2):**
  - Response: 9 outputs.
  - Column 6 and row 6 never affect any output.
  - `o_frame_done` at (2,2).
- **Gapped input:** random 0–3 idle cycles between pixels.
  - Response: output values and order identical to the gapless run.
  - Each output occurs 1 cycle after its last window pixel.
- **Abort:** assert `i_clear` at pixel (5,3), with `i_valid` high in the same cycle, then restart the frame.
  - Response: no output in the cycle after the clear.
  - The restarted frame yields exactly 144 correct outputs.
- **Reset:** assert `reset_n` low mid-frame.
  - Response: all outputs 0 immediately.
  - The next frame after release is fully correct; back-to-back frames produce 2 `o_frame_done` pulses.
